// File: rtl/cavlc_level_decode_gen2.sv
// CAVLC level decoder: trailing-one signs, then level_prefix/level_suffix
// codes pulled from a barrel-shifter window, one signed level per handshake.
module cavlc_level_decode_gen2 #(
    parameter int WIN_W      = 16,
    parameter int LEVEL_W    = 16,
    parameter int MAX_COEFF  = 16,
    parameter int MAX_PREFIX = 15,
    parameter int CNT_W      = $clog2(MAX_COEFF + 1),
    parameter int SHIFT_W    = $clog2(WIN_W + 1)
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic                      Start,
    input  logic [CNT_W-1:0]          TotalCoeff,
    input  logic [1:0]                TrailingOnes,
    input  logic [WIN_W-1:0]          Bits,
    input  logic                      BitsValid,
    output logic [SHIFT_W-1:0]        NumShift,
    output logic                      ShiftEn,
    output logic signed [LEVEL_W-1:0] LevelOut,
    output logic [CNT_W-1:0]          LevelIdx,
    output logic                      LevelValid,
    input  logic                      LevelReady,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Error
);

    localparam int LCW = LEVEL_W + 2;
    localparam int MW  = LCW + 1;
    localparam logic [MW-1:0] POS_MAX = (MW'(1) << (LEVEL_W - 1)) - MW'(1);

    typedef enum logic [2:0] {IDLE, T1, PREFIX, SUFFIX, FIN} stateT;

    stateT state, nextState;

    logic [CNT_W-1:0]   tcR;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         t1R;
    logic [2:0]         sL;
    logic               firstR;
    logic               errR;
    logic               errNext;
    logic [SHIFT_W-1:0] prefixR;
    logic [SHIFT_W-1:0] sizeR;

    logic               idle;
    logic               startGo;
    logic               badStart;
    logic               parsing;
    logic               accept;
    logic               lastAccept;
    logic               step;
    logic               prefixErr;
    logic               levelDone;
    logic               loadSuffix;
    logic [SHIFT_W-1:0] lz;
    logic [SHIFT_W-1:0] sizeCur;
    logic [SHIFT_W-1:0] pfx;
    logic [SHIFT_W-1:0] pMin;
    logic [WIN_W-1:0]   suf;
    logic [LCW-1:0]     lc;
    logic [MW-1:0]      mag;
    logic [MW-1:0]      magSat;
    logic [MW-1:0]      thr;
    logic               neg;
    logic [LEVEL_W-1:0] levelVal;
    logic [2:0]         sLa;
    logic [2:0]         sLn;
    int                 escSh;

    // Leading zeros from the MSB; WIN_W means no 1 in the window.
    function automatic logic [SHIFT_W-1:0] lzc(input logic [WIN_W-1:0] b);
        lzc = SHIFT_W'(WIN_W);
        for (int i = 0; i < WIN_W; i++) begin
            if (b[i]) lzc = SHIFT_W'(WIN_W - 1 - i);
        end
    endfunction

    assign idle       = (state == IDLE) || (state == FIN);
    assign startGo    = idle && Start;
    assign badStart   = (int'(TotalCoeff) > MAX_COEFF)
                     || (CNT_W'(TrailingOnes) > TotalCoeff);
    assign parsing    = ((state == T1) || (state == PREFIX) || (state == SUFFIX))
                     && (cnt < tcR);
    assign accept     = LevelValid && LevelReady;
    assign lastAccept = accept && !idle && (LevelIdx == tcR - CNT_W'(1));
    assign step       = parsing && BitsValid && (!LevelValid || LevelReady);
    assign lz         = lzc(Bits);
    assign prefixErr  = (int'(lz) >= WIN_W) || (int'(lz) > MAX_PREFIX);
    assign levelDone  = step && ((state == T1) || (state == SUFFIX)
                     || ((state == PREFIX) && !prefixErr && (sizeCur == '0)));
    assign loadSuffix = step && (state == PREFIX) && !prefixErr && (sizeCur != '0);

    always_comb begin
        pfx = (state == SUFFIX) ? prefixR : lz;
        suf = (state == SUFFIX) ? (Bits >> (WIN_W - int'(sizeR))) : '0;
        if ((lz == SHIFT_W'(14)) && (sL == 3'd0)) sizeCur = SHIFT_W'(4);
        else if (int'(lz) >= 15)                 sizeCur = lz - SHIFT_W'(3);
        else                                      sizeCur = SHIFT_W'(sL);
        pMin  = (int'(pfx) >= 15) ? SHIFT_W'(15) : pfx;
        escSh = int'(pfx) - 3;
        lc = (LCW'(pMin) << sL) + LCW'(suf);
        if ((int'(pfx) >= 15) && (sL == 3'd0)) lc = lc + LCW'(15);
        if (int'(pfx) >= 16) lc = lc + (LCW'(1) << escSh) - LCW'(4096);
        if (firstR && (t1R != 2'd3)) lc = lc + LCW'(2);
        if (state == T1) begin
            neg = Bits[WIN_W-1];
            mag = MW'(1);
        end else begin
            neg = lc[0];
            mag = lc[0] ? ((MW'(lc) + MW'(1)) >> 1) : ((MW'(lc) + MW'(2)) >> 1);
        end
        if (neg) magSat = (mag > POS_MAX + MW'(1)) ? POS_MAX + MW'(1) : mag;
        else     magSat = (mag > POS_MAX) ? POS_MAX : mag;
        levelVal = neg ? LEVEL_W'(~magSat + MW'(1)) : LEVEL_W'(magSat);
        // Suffix-length adaptation uses the unsaturated magnitude.
        sLa = (sL == 3'd0) ? 3'd1 : sL;
        thr = MW'(3) << (sLa - 3'd1);
        sLn = ((mag > thr) && (sLa < 3'd6)) ? sLa + 3'd1 : sLa;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            errR  <= 1'b0;
        end else begin
            state <= nextState;
            errR  <= errNext;
        end
    end

    always_comb begin
        nextState = state;
        errNext   = 1'b0;
        unique case (state)
            IDLE, FIN: begin
                nextState = IDLE;
                if (Start) begin
                    if (badStart) begin
                        nextState = FIN;
                        errNext   = 1'b1;
                    end else if (TotalCoeff == '0) nextState = FIN;
                    else if (TrailingOnes != 2'd0) nextState = T1;
                    else                            nextState = PREFIX;
                end
            end
            T1: begin
                if (lastAccept) nextState = FIN;
                else if (step)
                    nextState = (cnt + CNT_W'(1) < CNT_W'(t1R)) ? T1 : PREFIX;
            end
            PREFIX: begin
                if (lastAccept) nextState = FIN;
                else if (step && prefixErr) begin
                    nextState = FIN;
                    errNext   = 1'b1;
                end else if (loadSuffix) nextState = SUFFIX;
            end
            SUFFIX: begin
                if (step) nextState = PREFIX;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        Busy     = !idle;
        Done     = (state == FIN);
        Error    = (state == FIN) && errR;
        ShiftEn  = step && !((state == PREFIX) && prefixErr);
        NumShift = '0;
        if (ShiftEn) begin
            unique case (1'b1)
                state == T1:     NumShift = SHIFT_W'(1);
                state == PREFIX: NumShift = lz + SHIFT_W'(1);
                state == SUFFIX: NumShift = sizeR;
                default:         NumShift = '0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            tcR        <= '0;
            t1R        <= '0;
            cnt        <= '0;
            sL         <= '0;
            firstR     <= 1'b0;
            prefixR    <= '0;
            sizeR      <= '0;
            LevelOut   <= '0;
            LevelIdx   <= '0;
            LevelValid <= 1'b0;
        end else begin
            if (startGo) begin
                tcR    <= TotalCoeff;
                t1R    <= TrailingOnes;
                cnt    <= '0;
                sL     <= ((int'(TotalCoeff) > 10) && (TrailingOnes != 2'd3)) ? 3'd1 : 3'd0;
                firstR <= 1'b1;
            end else if (levelDone) begin
                LevelOut   <= levelVal;
                LevelIdx   <= cnt;
                LevelValid <= 1'b1;
                cnt        <= cnt + CNT_W'(1);
                if (state != T1) begin
                    sL     <= sLn;
                    firstR <= 1'b0;
                end
            end else if (accept) begin
                LevelValid <= 1'b0;
            end
            if (loadSuffix) begin
                prefixR <= lz;
                sizeR   <= sizeCur;
            end
        end
    end

endmodule

// File: tb/tb_cavlc_level_decode_gen2.sv
// Bench for cavlc_level_decode_gen2: directed bitstreams, expected levels and
// shift amounts queued up front, checked by a negedge monitor.
module tb_cavlc_level_decode_gen2;

    localparam int WIN_W   = 16;
    localparam int LEVEL_W = 16;
    localparam int CNT_W   = 5;
    localparam int SHIFT_W = 5;

    logic                      Clk = 1'b0;
    logic                      nReset = 1'b0;
    logic                      Start = 1'b0;
    logic [CNT_W-1:0]          TotalCoeff = '0;
    logic [1:0]                TrailingOnes = '0;
    logic [WIN_W-1:0]          Bits;
    logic                      BitsValid = 1'b0;
    logic [SHIFT_W-1:0]        NumShift;
    logic                      ShiftEn;
    logic signed [LEVEL_W-1:0] LevelOut;
    logic [CNT_W-1:0]          LevelIdx;
    logic                      LevelValid;
    logic                      LevelReady = 1'b1;
    logic                      Busy;
    logic                      Done;
    logic                      Error;

    logic [0:1023] bs;
    int            ptr;
    int            wp;
    logic          setPtr = 1'b1;
    int            vecs = 0;
    int            errs = 0;
    int            lvQ[$];
    int            idxQ[$];
    int            shQ[$];

    cavlc_level_decode_gen2 dut (
        .Clk(Clk), .nReset(nReset), .Start(Start),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes),
        .Bits(Bits), .BitsValid(BitsValid),
        .NumShift(NumShift), .ShiftEn(ShiftEn),
        .LevelOut(LevelOut), .LevelIdx(LevelIdx),
        .LevelValid(LevelValid), .LevelReady(LevelReady),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    assign Bits = bs[ptr +: WIN_W];

    always @(posedge Clk) begin
        if (setPtr)       ptr <= 0;
        else if (ShiftEn) ptr <= ptr + int'(NumShift);
    end

    task automatic check(string name, int act, int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge Clk);
            if (nReset && ShiftEn) begin
                if (shQ.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL unexpected shift: NumShift %0d, none expected", NumShift);
                end else check("NumShift", int'(NumShift), shQ.pop_front());
            end
            if (nReset && LevelValid && LevelReady) begin
                if (lvQ.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL unexpected level: %0d idx %0d, none expected", LevelOut, LevelIdx);
                end else begin
                    check("LevelOut", int'(LevelOut), lvQ.pop_front());
                    check("LevelIdx", int'(LevelIdx), idxQ.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearStream();
        bs = '0;
        wp = 0;
    endtask

    task automatic put(string s);
        for (int i = 0; i < s.len(); i++) begin
            bs[wp] = (s[i] == 8'h31);
            wp++;
        end
    endtask

    task automatic putZ(int n);
        for (int i = 0; i < n; i++) begin
            bs[wp] = 1'b0;
            wp++;
        end
    endtask

    task automatic expLevel(int lvl, int idx);
        lvQ.push_back(lvl);
        idxQ.push_back(idx);
    endtask

    task automatic expShift(int n);
        shQ.push_back(n);
    endtask

    task automatic rewind();
        setPtr = 1'b1;
        tick();
        setPtr = 1'b0;
    endtask

    task automatic startBlock(int tc, int t1);
        TotalCoeff   = tc[CNT_W-1:0];
        TrailingOnes = t1[1:0];
        Start        = 1'b1;
        tick();
        Start        = 1'b0;
    endtask

    task automatic waitDone(string name, int expErr);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge Clk);
            if (Done) break;
            n++;
        end
        if (n >= 300) begin
            vecs++; errs++;
            $display("FAIL %s Done: got timeout, expected pulse", name);
        end else begin
            check({name, " Error"}, int'(Error), expErr);
            check({name, " Busy"}, int'(Busy), 0);
        end
        check({name, " pending"}, lvQ.size() + shQ.size(), 0);
        lvQ.delete();
        idxQ.delete();
        shQ.delete();
        tick();
    endtask

    task automatic quickDone(string name, int tc, int t1, int expErr);
        startBlock(tc, t1);
        @(negedge Clk);
        check({name, " Done"}, int'(Done), 1);
        check({name, " Error"}, int'(Error), expErr);
        check({name, " Busy"}, int'(Busy), 0);
        tick();
    endtask

    initial begin
        int n;
        bs = '0;
        wp = 0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst Busy", int'(Busy), 0);
        check("rst Done", int'(Done), 0);
        check("rst Error", int'(Error), 0);
        check("rst LevelValid", int'(LevelValid), 0);
        check("rst ShiftEn", int'(ShiftEn), 0);
        check("rst LevelOut", int'(LevelOut), 0);
        nReset = 1'b1;
        tick();
        setPtr    = 1'b0;
        BitsValid = 1'b1;

        // TC=3 T1=2: +1, -1, then prefix 0 with +2 bias
        clearStream(); put("011"); rewind();
        expShift(1); expShift(1); expShift(1);
        expLevel(1, 0); expLevel(-1, 1); expLevel(2, 2);
        startBlock(3, 2);
        waitDone("t1mix", 0);

        // TC=11 T1=0: sL starts at 1
        clearStream(); put("11");
        for (int i = 0; i < 10; i++) put("10");
        rewind();
        expShift(1); expShift(1); expLevel(-2, 0);
        for (int i = 1; i <= 10; i++) begin
            expShift(1); expShift(1); expLevel(1, i);
        end
        startBlock(11, 0);
        waitDone("sl1", 0);

        // prefix 14 escape with sL=0
        clearStream(); put("001"); putZ(14); put("1"); put("0101"); rewind();
        expShift(1); expShift(1); expShift(1); expShift(15); expShift(4);
        expLevel(1, 0); expLevel(1, 1); expLevel(-1, 2); expLevel(-10, 3);
        startBlock(4, 3);
        waitDone("pfx14", 0);

        // suffix-length growth 0 -> 1 -> 2
        clearStream(); put("1"); put("00010"); put("100"); rewind();
        expShift(1); expShift(4); expShift(1); expShift(1); expShift(2);
        expLevel(2, 0); expLevel(4, 1); expLevel(1, 2);
        startBlock(3, 0);
        waitDone("slgrow", 0);

        // prefix 15 escape, 12-bit suffix
        clearStream(); putZ(15); put("1"); put("000000000101"); rewind();
        expShift(16); expShift(12); expLevel(-19, 0);
        startBlock(1, 0);
        waitDone("pfx15", 0);

        // consumer back-pressure
        clearStream(); put("01"); rewind();
        expShift(1); expShift(1); expLevel(1, 0); expLevel(-1, 1);
        LevelReady = 1'b0;
        startBlock(2, 2);
        n = 0;
        while (!LevelValid && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("stall LevelValid", int'(LevelValid), 1);
        for (int k = 0; k < 3; k++) begin
            check("stall LevelOut", int'(LevelOut), 1);
            check("stall LevelIdx", int'(LevelIdx), 0);
            check("stall ShiftEn", int'(ShiftEn), 0);
            @(negedge Clk);
        end
        @(posedge Clk);
        #1;
        LevelReady = 1'b1;
        waitDone("stall", 0);

        quickDone("tc0", 0, 0, 0);
        quickDone("t1>tc", 2, 3, 1);
        quickDone("tc>max", 17, 0, 1);

        // window with no 1 while parsing a prefix
        clearStream(); rewind();
        startBlock(1, 0);
        waitDone("zerowin", 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("zerowin LevelValid", int'(LevelValid), 0);
        end
        tick();

        // asynchronous reset mid-block
        BitsValid = 1'b0;
        clearStream(); put("1"); rewind();
        startBlock(3, 0);
        tick();
        check("midrst Busy before", int'(Busy), 1);
        nReset = 1'b0;
        #1;
        check("midrst Busy", int'(Busy), 0);
        check("midrst Done", int'(Done), 0);
        check("midrst Error", int'(Error), 0);
        check("midrst LevelValid", int'(LevelValid), 0);
        check("midrst ShiftEn", int'(ShiftEn), 0);
        check("midrst NumShift", int'(NumShift), 0);
        check("midrst LevelOut", int'(LevelOut), 0);
        tick();
        nReset    = 1'b1;
        BitsValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("postrst Done", int'(Done), 0);
            check("postrst Busy", int'(Busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
